// File: rtl/axi_frame_pkg.sv
// ---------------------------------------------------------------------------
// axi_frame_pkg
// Constants shared by the DDR frame reader and the camera-side frame writer:
// AXI4 attribute encodings, frame geometry and the reader FSM state encoding.
// ---------------------------------------------------------------------------
package axi_frame_pkg;

  // AXI4 attribute encodings
  localparam logic [2:0] SIZE_8B                     = 3'b011;
  localparam logic [1:0] BURST_INCR                  = 2'b01;
  localparam logic [3:0] CACHE_BUFFERABLE_MODIFIABLE = 4'b0011;
  localparam logic [2:0] PROT_UNPRIV_SECURE_DATA     = 3'b000;

  // Frame geometry: 320x240 RGB565, 64 beats of 8 bytes per burst
  localparam int FRAME_BYTES = 153600;
  localparam int BURST_BYTES = 512;

  // Reader FSM state encoding (visible on the debug port)
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPACE = 2'd1,
    ST_ADDR_SEND  = 2'd2,
    ST_DATA_RECV  = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head word is always visible
// on o_data while o_empty is low; i_pop consumes it. Synchronous reset
// flushes the pointers and occupancy (memory contents are not cleared).
// Ports:
//   clk      clock
//   rst      synchronous active-high flush
//   i_push   write i_data (ignored when full)
//   i_data   write data
//   i_pop    consume head word (ignored when empty)
//   o_data   head word
//   o_empty  FIFO holds no words
//   o_count  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign w_full    = (r_count == CNT_FULL);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write port
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi4_frame_reader.sv
// ---------------------------------------------------------------------------
// axi4_frame_reader
// AXI4 read master fetching one RGB565 frame from DDR as a sequence of
// fixed-length INCR bursts, one outstanding at a time. Beats are buffered in
// an FWFT FIFO and presented as a valid/ready 64-bit stream. A burst is only
// requested once the FIFO has room for all of its beats, so RREADY can stay
// high for the whole burst.
// Ports:
//   clk_100Mhz, rst            clock, synchronous active-high reset
//   FRAME_BASE_ADDR            frame base byte address
//   frame_start                rising edge starts a frame fetch (IDLE only)
//   AR* / R*                   AXI4 read address and read data channels
//   m_data, m_valid, m_ready   output stream (FIFO head)
//   reader_done                one-cycle pulse after the last beat of a frame
//   rd_err                     sticky: bad RRESP or misplaced RLAST
//   state, ADDR_OFFSET         debug: FSM state and current frame offset
// ---------------------------------------------------------------------------
module axi4_frame_reader
  import axi_frame_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_BEATS    = 64,
  parameter int FRAME_BYTES    = axi_frame_pkg::FRAME_BYTES,
  parameter int FIFO_DEPTH     = 256
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  input  logic                      frame_start,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  output logic [AXI_DATA_WIDTH-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      reader_done,
  output logic                      rd_err,
  output logic [1:0]                state,
  output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET
);

  localparam int BEAT_W        = $clog2(BURST_BEATS);
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;
  localparam int BURST_BYTES_L = BURST_BEATS * 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] LAST_OFFSET = AXI_ADDR_WIDTH'(FRAME_BYTES - BURST_BYTES_L);
  localparam logic [AXI_ADDR_WIDTH-1:0] OFFSET_STEP = AXI_ADDR_WIDTH'(BURST_BYTES_L);
  localparam logic [CNT_W-1:0]          SPACE_LIMIT = CNT_W'(FIFO_DEPTH - BURST_BEATS);
  localparam logic [BEAT_W-1:0]         LAST_BEAT   = BEAT_W'(BURST_BEATS - 1);
  localparam logic [BEAT_W-1:0]         BEAT_ONE    = BEAT_W'(1);

  state_t                    r_state;
  state_t                    w_next_state;
  logic                      r_fs_d;
  logic                      r_fs_edge;
  logic [AXI_ADDR_WIDTH-1:0] r_base;
  logic [AXI_ADDR_WIDTH-1:0] r_offset;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic                      r_arvalid;
  logic                      r_rready;
  logic [BEAT_W-1:0]         r_beat;
  logic                      r_done;
  logic                      r_err;

  logic                      w_ar_fire;
  logic                      w_r_fire;
  logic                      w_last_beat;
  logic                      w_last_burst;
  logic                      w_space_ok;
  logic                      w_fifo_empty;
  logic                      w_pop;
  logic [CNT_W-1:0]          w_fifo_count;

  assign w_ar_fire    = r_arvalid & ARREADY;
  assign w_r_fire     = RVALID & r_rready;
  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_last_burst = (r_offset == LAST_OFFSET);
  assign w_space_ok   = (w_fifo_count <= SPACE_LIMIT);
  assign w_pop        = ~w_fifo_empty & m_ready;

  sync_fifo_fwft #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_100Mhz),
    .rst     (rst),
    .i_push  (w_r_fire),
    .i_data  (RDATA),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_fs_edge) w_next_state = ST_WAIT_SPACE;
        else           w_next_state = ST_IDLE;
      end
      ST_WAIT_SPACE: begin
        if (w_space_ok) w_next_state = ST_ADDR_SEND;
        else            w_next_state = ST_WAIT_SPACE;
      end
      ST_ADDR_SEND: begin
        if (w_ar_fire) w_next_state = ST_DATA_RECV;
        else           w_next_state = ST_ADDR_SEND;
      end
      ST_DATA_RECV: begin
        if (w_r_fire && w_last_beat) begin
          if (w_last_burst) w_next_state = ST_IDLE;
          else              w_next_state = ST_WAIT_SPACE;
        end else begin
          w_next_state = ST_DATA_RECV;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_100Mhz) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Datapath registers: edge detect, burst addressing, beat count, status
  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      r_fs_d    <= 1'b0;
      r_fs_edge <= 1'b0;
      r_base    <= {AXI_ADDR_WIDTH{1'b0}};
      r_offset  <= {AXI_ADDR_WIDTH{1'b0}};
      r_araddr  <= {AXI_ADDR_WIDTH{1'b0}};
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_beat    <= {BEAT_W{1'b0}};
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // Edge is registered, so a frame request is acted on one cycle later
      r_fs_d    <= frame_start;
      r_fs_edge <= frame_start & ~r_fs_d;
      r_done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_fs_edge) begin
            r_base   <= FRAME_BASE_ADDR;
            r_offset <= {AXI_ADDR_WIDTH{1'b0}};
          end
        end
        ST_WAIT_SPACE: begin
          if (w_space_ok) begin
            r_araddr  <= r_base + r_offset;
            r_arvalid <= 1'b1;
          end
        end
        ST_ADDR_SEND: begin
          if (w_ar_fire) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        ST_DATA_RECV: begin
          if (w_r_fire) begin
            // Errors are flagged but never shorten the burst
            if ((RRESP != 2'b00) || (RLAST != w_last_beat)) begin
              r_err <= 1'b1;
            end
            if (w_last_beat) begin
              r_rready <= 1'b0;
              r_beat   <= {BEAT_W{1'b0}};
              if (w_last_burst) begin
                r_done   <= 1'b1;
                r_offset <= {AXI_ADDR_WIDTH{1'b0}};
              end else begin
                r_offset <= r_offset + OFFSET_STEP;
              end
            end else begin
              r_beat <= r_beat + BEAT_ONE;
            end
          end
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
        end
      endcase
    end
  end

  assign ARADDR      = r_araddr;
  assign ARVALID     = r_arvalid;
  assign ARLEN       = 8'(BURST_BEATS - 1);
  assign ARSIZE      = SIZE_8B;
  assign ARBURST     = BURST_INCR;
  assign ARCACHE     = CACHE_BUFFERABLE_MODIFIABLE;
  assign ARPROT      = PROT_UNPRIV_SECURE_DATA;
  assign RREADY      = r_rready;
  assign m_valid     = ~w_fifo_empty;
  assign reader_done = r_done;
  assign rd_err      = r_err;
  assign state       = r_state;
  assign ADDR_OFFSET = r_offset;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_axi4_frame_reader
// Scoreboard bench: each frame request pushes the expected burst addresses
// and stream words into queues; a DDR slave model and a stream monitor pop
// and compare as the DUT presents AR handshakes and stream words.
// DDR content model: word at byte address a is {~a, a}.
// ---------------------------------------------------------------------------
module tb_axi4_frame_reader;

  logic        clk_100Mhz = 1'b0;
  logic        rst;
  logic [31:0] FRAME_BASE_ADDR;
  logic        frame_start;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        reader_done;
  logic        rd_err;
  logic [1:0]  state;
  logic [31:0] ADDR_OFFSET;

  always #5 clk_100Mhz = ~clk_100Mhz;

  axi4_frame_reader dut (
    .clk_100Mhz      (clk_100Mhz),
    .rst             (rst),
    .FRAME_BASE_ADDR (FRAME_BASE_ADDR),
    .frame_start     (frame_start),
    .ARADDR          (ARADDR),
    .ARVALID         (ARVALID),
    .ARREADY         (ARREADY),
    .ARLEN           (ARLEN),
    .ARSIZE          (ARSIZE),
    .ARBURST         (ARBURST),
    .ARCACHE         (ARCACHE),
    .ARPROT          (ARPROT),
    .RDATA           (RDATA),
    .RRESP           (RRESP),
    .RLAST           (RLAST),
    .RVALID          (RVALID),
    .RREADY          (RREADY),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .reader_done     (reader_done),
    .rd_err          (rd_err),
    .state           (state),
    .ADDR_OFFSET     (ADDR_OFFSET)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];

  int ar_delay     = 0;
  int ar_cnt       = 0;
  int slv_burst    = 0;
  int slv_beat     = 0;
  bit slv_active   = 1'b0;
  int inject_burst = -1;
  int done_cnt     = 0;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: observed %0h", name, act);
  endtask

  // DDR slave model: drives inputs 1 time unit after the falling edge
  initial begin : slave
    int          ar_wait;
    bit          ar_pend;
    bit          r_pend;
    bit          err_pend;
    logic [31:0] burst_addr;
    ar_wait = 0; ar_pend = 1'b0; r_pend = 1'b0; err_pend = 1'b0; burst_addr = 32'h0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = 64'h0; RRESP = 2'b00; RLAST = 1'b0;
    forever begin
      @(negedge clk_100Mhz);
      #1;
      if (rst) begin
        ar_wait = 0; ar_pend = 1'b0; r_pend = 1'b0; err_pend = 1'b0;
        slv_active = 1'b0; slv_beat = 0;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      end else begin
        if (ar_pend) begin
          slv_active = 1'b1; slv_beat = 0; ar_pend = 1'b0;
        end
        if (r_pend) begin
          if (err_pend) begin
            check("rd_err_set", {63'h0, rd_err}, 64'h1);
            err_pend = 1'b0;
          end
          slv_beat++;
          r_pend = 1'b0;
          if (slv_beat == 64) begin
            slv_active = 1'b0;
            slv_burst++;
          end
        end
        ARREADY = 1'b0;
        if (ARVALID && slv_active) begin
          fail_now("ar_overlap", {32'h0, ARADDR});
        end else if (ARVALID && !ar_pend) begin
          if (exp_addr.size() == 0) fail_now("ar_unexpected", {32'h0, ARADDR});
          else                      check("araddr", {32'h0, ARADDR}, {32'h0, exp_addr[0]});
          if (ar_wait < ar_delay) begin
            ar_wait++;
          end else begin
            ARREADY = 1'b1; ar_pend = 1'b1; ar_wait = 0; ar_cnt++;
            burst_addr = ARADDR;
            if (exp_addr.size() > 0) void'(exp_addr.pop_front());
          end
        end else if (!ARVALID && ar_wait > 0) begin
          fail_now("arvalid_dropped", 64'(ar_wait));
          ar_wait = 0;
        end
        if (slv_active) begin
          RVALID = 1'b1;
          RDATA  = pat(burst_addr + 32'(slv_beat * 8));
          RLAST  = (slv_beat == 63);
          RRESP  = (slv_burst == inject_burst && slv_beat == 10) ? 2'b10 : 2'b00;
          if (RREADY) begin
            r_pend = 1'b1;
            if (RRESP != 2'b00) begin
              check("rd_err_before", {63'h0, rd_err}, 64'h0);
              err_pend = 1'b1;
            end
          end
        end else begin
          RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        end
      end
    end
  end

  // Stream monitor: compares each accepted word with the scoreboard head
  initial begin : monitor
    forever begin
      @(negedge clk_100Mhz);
      #2;
      if (reader_done) done_cnt++;
      if (m_valid && m_ready && !rst) begin
        if (exp_data.size() == 0) fail_now("m_data_unexpected", m_data);
        else                      check("m_data", m_data, exp_data.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},   64'(state), 64'h0);
    check({tag, "_arvalid"}, 64'(ARVALID), 64'h0);
    check({tag, "_rready"},  64'(RREADY), 64'h0);
    check({tag, "_araddr"},  64'(ARADDR), 64'h0);
    check({tag, "_offset"},  64'(ADDR_OFFSET), 64'h0);
    check({tag, "_done"},    64'(reader_done), 64'h0);
    check({tag, "_rd_err"},  64'(rd_err), 64'h0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'h0);
  endtask

  // Queues the whole frame, raises frame_start and checks ARVALID latency
  task automatic start_frame(input logic [31:0] base);
    for (int k = 0; k < 300; k++) exp_addr.push_back(base + 32'(k * 512));
    for (int i = 0; i < 19200; i++) exp_data.push_back(pat(base + 32'(i * 8)));
    ar_cnt = 0; slv_burst = 0; done_cnt = 0;
    FRAME_BASE_ADDR = base;
    frame_start = 1'b1;
    @(negedge clk_100Mhz);
    @(negedge clk_100Mhz);
    check("arvalid_latency_early", 64'(ARVALID), 64'h0);
    @(negedge clk_100Mhz);
    check("arvalid_latency", 64'(ARVALID), 64'h1);
    frame_start = 1'b0;
  endtask

  task automatic wait_ar(input int n, input int max_cycles);
    int c;
    c = 0;
    while (ar_cnt < n && c < max_cycles) begin
      @(negedge clk_100Mhz);
      c++;
    end
    if (ar_cnt < n) fail_now("timeout_ar", 64'(ar_cnt));
  endtask

  task automatic wait_done(input int max_cycles);
    int c;
    c = 0;
    while (done_cnt == 0 && c < max_cycles) begin
      @(negedge clk_100Mhz);
      c++;
    end
    if (done_cnt == 0) fail_now("timeout_done", 64'(ar_cnt));
    repeat (100) @(negedge clk_100Mhz);
  endtask

  initial begin : main
    int c;
    rst = 1'b1; frame_start = 1'b0; FRAME_BASE_ADDR = 32'h0; m_ready = 1'b1;
    repeat (3) @(negedge clk_100Mhz);
    check_reset_outputs("reset");
    check("arlen",   64'(ARLEN), 64'd63);
    check("arsize",  64'(ARSIZE), 64'h3);
    check("arburst", 64'(ARBURST), 64'h1);
    check("arcache", 64'(ARCACHE), 64'h3);
    check("arprot",  64'(ARPROT), 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk_100Mhz);

    // Frame 1: ARREADY delayed 5 cycles, error on burst 3 beat 10, stray edge
    ar_delay = 5; inject_burst = 3;
    start_frame(32'h1000_0000);
    wait_ar(100, 20000);
    FRAME_BASE_ADDR = 32'h2000_0000;
    frame_start = 1'b1;
    repeat (3) @(negedge clk_100Mhz);
    check("stray_edge_ignored", 64'(state == 2'd0), 64'h0);
    frame_start = 1'b0;
    wait_done(30000);
    check("f1_done_count", 64'(done_cnt), 64'd1);
    check("f1_bursts",     64'(ar_cnt), 64'd300);
    check("f1_rd_err",     64'(rd_err), 64'h1);
    check("f1_state_idle", 64'(state), 64'h0);
    check("f1_offset",     64'(ADDR_OFFSET), 64'h0);
    check("f1_all_words",  64'(exp_data.size()), 64'h0);

    // Frame 2: stream stalled, FIFO fills to 256 words and the FSM parks
    ar_delay = 0; inject_burst = -1; m_ready = 1'b0;
    start_frame(32'h3000_0000);
    repeat (1000) @(negedge clk_100Mhz);
    check("stall_bursts",  64'(ar_cnt), 64'd4);
    check("stall_state",   64'(state), 64'h1);
    check("stall_arvalid", 64'(ARVALID), 64'h0);
    check("stall_m_valid", 64'(m_valid), 64'h1);
    m_ready = 1'b1;
    repeat (63) @(negedge clk_100Mhz);
    m_ready = 1'b0;
    repeat (5) @(negedge clk_100Mhz);
    check("pop63_bursts",  64'(ar_cnt), 64'd4);
    check("pop63_arvalid", 64'(ARVALID), 64'h0);
    m_ready = 1'b1;
    repeat (3) @(negedge clk_100Mhz);
    check("pop64_bursts",  64'(ar_cnt), 64'd5);
    wait_done(30000);
    check("f2_done_count", 64'(done_cnt), 64'd1);
    check("f2_bursts",     64'(ar_cnt), 64'd300);
    check("f2_rd_err_sticky", 64'(rd_err), 64'h1);
    check("f2_all_words",  64'(exp_data.size()), 64'h0);

    // Frame 3: reset on beat 30 of a burst, then a fresh frame from offset 0
    start_frame(32'h4000_0000);
    wait_ar(2, 2000);
    c = 0;
    while (!(slv_active && slv_beat == 30) && c < 2000) begin
      @(negedge clk_100Mhz);
      c++;
    end
    if (!(slv_active && slv_beat == 30)) fail_now("timeout_beat30", 64'(slv_beat));
    rst = 1'b1;
    @(negedge clk_100Mhz);
    check_reset_outputs("midburst_reset");
    exp_addr.delete(); exp_data.delete();
    @(negedge clk_100Mhz);
    rst = 1'b0;
    repeat (3) @(negedge clk_100Mhz);
    start_frame(32'h5000_0000);
    wait_ar(3, 2000);
    repeat (20) @(negedge clk_100Mhz);
    check("restart_rd_err", 64'(rd_err), 64'h0);
    check("restart_offset", 64'(ADDR_OFFSET), 64'd1024);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4_frame_reader.md
Name: axi4_frame_reader

Overview:
AXI4 read master that fetches one 320x240 RGB565 frame (153600 bytes) from DDR as 300 INCR bursts of 64x64-bit beats. It buffers the beats in an internal FWFT FIFO and presents them as a valid/ready 64-bit stream to the HDMI output path. It is the DDR-to-display counterpart of the camera-side frame writer and shares its base-address and double-buffer scheme. Clock-domain crossing to the pixel clock is handled downstream, outside this block.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI and stream data width (fixed at 64)
BURST_BEATS, 64, beats per burst; ARLEN = BURST_BEATS-1
FRAME_BYTES, 153600, bytes per frame; must be a multiple of BURST_BEATS*8
FIFO_DEPTH, 256, internal FIFO depth in words (power of 2, >= 2*BURST_BEATS)

Ports:
clk_100Mhz  in  1  sole clock
rst  in  1  reset; synchronous, active-high
FRAME_BASE_ADDR  in  32  frame base byte address, sampled on frame_start edge
frame_start  in  1  level; rising edge requests a frame fetch
ARADDR  out  32  burst start address
ARVALID  out  1  address valid
ARREADY  in  1  address ready
ARLEN  out  8  constant BURST_BEATS-1 (63)
ARSIZE  out  3  constant 3'b011 (8 bytes)
ARBURST  out  2  constant 2'b01 (INCR)
ARCACHE  out  4  constant 4'b0011
ARPROT  out  3  constant 3'b000
RDATA  in  64  read data
RRESP  in  2  read response
RLAST  in  1  last beat of burst
RVALID  in  1  read data valid
RREADY  out  1  read data ready
m_data  out  64  stream data (FIFO head)
m_valid  out  1  stream valid
m_ready  in  1  stream ready
reader_done  out  1  one-cycle pulse after the final beat of the frame is accepted
rd_err  out  1  sticky error flag
state  out  2  current FSM state (debug)
ADDR_OFFSET  out  32  current byte offset within the frame (debug)

Behaviour:
- Reset (synchronous): state=IDLE, ARVALID=0, RREADY=0, ARADDR=0, ADDR_OFFSET=0, reader_done=0, rd_err=0, beat count=0, FIFO flushed, m_valid=0. frame_start edge register cleared to 0. Reset during a burst abandons that burst; the interconnect must be reset together with this block.
- States: IDLE(0), WAIT_SPACE(1), ADDR_SEND(2), DATA_RECV(3).
- IDLE: on the frame_start rising edge (registered compare), latch base = FRAME_BASE_ADDR, set ADDR_OFFSET=0, go to WAIT_SPACE. A frame_start edge outside IDLE is ignored.
- WAIT_SPACE: when FIFO occupancy <= FIFO_DEPTH-BURST_BEATS (192 at default depth), register ARADDR = base + ADDR_OFFSET, set ARVALID=1, and go to ADDR_SEND.
- ADDR_SEND: hold ARVALID and ARADDR stable until ARREADY. On ARVALID&&ARREADY, drop ARVALID, set RREADY=1, and go to DATA_RECV. Only one burst is outstanding at a time.
- DATA_RECV: each RVALID&&RREADY pushes RDATA into the FIFO and increments the beat count (6-bit). Space is pre-reserved, so RREADY stays 1 for the whole burst and the FIFO never overflows.
- RRESP != 0 on any beat sets rd_err. RLAST mismatched with beat count==63 also sets rd_err. The burst still terminates on beat 63.
- On beat 63: RREADY=0 and beat count=0. If ADDR_OFFSET == FRAME_BYTES-512 (153088), pulse reader_done for 1 cycle, reset ADDR_OFFSET to 0, and go to IDLE. Otherwise ADDR_OFFSET += 512 and go to WAIT_SPACE.
- Latency: the first ARVALID is asserted 2 cycles after the cycle in which frame_start is first sampled high, provided the FIFO is empty.
- Stream side: m_valid = FIFO not empty and m_data = FIFO head (FWFT). A word pops on m_valid&&m_ready. A simultaneous push and pop leaves occupancy unchanged.
- Occupancy counter width is log2(FIFO_DEPTH)+1. Address arithmetic is 32-bit unsigned, with no wrap check.
- rd_err clears only on rst.

Decomposition:
- Package axi_frame_pkg: AXI constant encodings (SIZE_8B, BURST_INCR, CACHE_BUFFERABLE_MODIFIABLE), state localparams, FRAME_BYTES and BURST_BYTES, shared with the writer.
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH): single clock, FWFT output, occupancy count output, synchronous reset flush.

Test Plan:
- Frame_start edge with ARREADY tied 1, RVALID always, m_ready=1 -> 300 bursts at ARADDR base, base+512 … base+153088; 19200 words out in order; reader_done pulses once.
- m_ready=0 throughout -> exactly 4 bursts issued (256 words); FSM parks in WAIT_SPACE; no ARVALID until m_ready pops ≥64 words.
- ARREADY delayed 5 cycles -> ARVALID and ARADDR stable over those cycles; exactly one handshake per burst.
- RRESP=2'b10 on beat 10 of burst 3 -> rd_err=1 from the next cycle; frame completes; rd_err persists until rst.
- Second frame_start edge mid-frame -> ignored; offsets continue unchanged; a new edge after reader_done restarts at the new FRAME_BASE_ADDR.
- rst asserted on beat 30 of a burst -> next cycle all outputs at reset values, m_valid=0; a new frame restarts at offset 0.
